// File: rtl/display_sequencer.sv
// MAX7219 display sequencer: initialises the driver, then streams six BCD digit words
// per frame request and single intensity words on demand through an external SPI master.
module display_sequencer #(
  parameter logic [3:0] INIT_INTENSITY = 4'h8,
  parameter logic [5:0] DP_MASK        = 6'b010100
) (
  input  logic        clk,
  input  logic        res,
  input  logic        tick,
  input  logic        ena,
  input  logic [21:0] digits,
  input  logic [3:0]  int_val,
  input  logic        int_req,
  input  logic        ready,
  input  logic        sent,
  output logic        cs,
  output logic [15:0] word,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FRAME = 2'd2,
    ST_CFG   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_XFER = 2'd1,
    PH_GAP  = 2'd2
  } phase_t;

  state_t      state_r, state_s;
  phase_t      phase_r, phase_s;
  logic [2:0]  idx_r, idx_s;
  logic        cs_r, cs_s;
  logic [15:0] word_r, word_s;
  logic        busy_r;
  logic        frame_done_r, frame_done_s;
  logic        tick_q_r;
  logic        tick_pend_r;
  logic        overrun_r;
  logic        int_pend_r;
  logic [3:0]  int_val_r;
  logic [3:0]  cfg_val_r;
  logic [21:0] snap_r;
  logic        tick_edge_s;
  logic        tick_clr_s;
  logic        int_clr_s;
  logic        snap_load_s;
  logic [15:0] cur_word_s;
  logic        last_s;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h0C01;
      3'd1:    w = 16'h0F00;
      3'd2:    w = 16'h09FF;
      3'd3:    w = 16'h0B05;
      3'd4:    w = {12'h0A0, INIT_INTENSITY};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Digit register k = idx+1; tens fields for seconds and minutes are only 3 bits wide.
  function automatic logic [15:0] digit_word(input logic [21:0] snap, input logic [2:0] idx);
    logic [3:0] d;
    logic       dp;
    case (idx)
      3'd0:    begin d = snap[3:0];            dp = DP_MASK[0]; end
      3'd1:    begin d = snap[7:4];            dp = DP_MASK[1]; end
      3'd2:    begin d = snap[11:8];           dp = DP_MASK[2]; end
      3'd3:    begin d = {1'b0, snap[14:12]};  dp = DP_MASK[3]; end
      3'd4:    begin d = snap[18:15];          dp = DP_MASK[4]; end
      3'd5:    begin d = {1'b0, snap[21:19]};  dp = DP_MASK[5]; end
      default: begin d = 4'h0;                 dp = 1'b0;       end
    endcase
    return {5'b00000, idx + 3'd1, dp, 3'b000, d};
  endfunction

  assign tick_edge_s = tick & ~tick_q_r;

  // word to issue for the current state/index and whether it is the last of its sequence
  always_comb begin
    cur_word_s = 16'h0000;
    last_s     = 1'b1;
    case (state_r)
      ST_INIT: begin
        cur_word_s = init_word(idx_r);
        last_s     = (idx_r == 3'd4);
      end
      ST_FRAME: begin
        cur_word_s = digit_word(snap_r, idx_r);
        last_s     = (idx_r == 3'd5);
      end
      ST_CFG: begin
        cur_word_s = {8'h0A, 4'h0, cfg_val_r};
        last_s     = 1'b1;
      end
      default: begin
        cur_word_s = 16'h0000;
        last_s     = 1'b1;
      end
    endcase
  end

  // next-state, handshake and dispatch decisions
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    idx_s        = idx_r;
    cs_s         = cs_r;
    word_s       = word_r;
    frame_done_s = 1'b0;
    tick_clr_s   = 1'b0;
    int_clr_s    = 1'b0;
    snap_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cs_s    = 1'b1;
        phase_s = PH_LOAD;
        idx_s   = 3'd0;
        if (int_pend_r) begin
          state_s   = ST_CFG;
          int_clr_s = 1'b1;
        end else if (tick_pend_r && ena) begin
          state_s     = ST_FRAME;
          tick_clr_s  = 1'b1;
          snap_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        case (phase_r)
          PH_LOAD: begin
            if (ready && !sent) begin
              word_s  = cur_word_s;
              cs_s    = 1'b0;
              phase_s = PH_XFER;
            end else begin
              cs_s    = 1'b1;
              phase_s = PH_LOAD;
            end
          end
          PH_XFER: begin
            if (sent) begin
              cs_s    = 1'b1;
              phase_s = PH_GAP;
            end else begin
              cs_s    = 1'b0;
              phase_s = PH_XFER;
            end
          end
          PH_GAP: begin
            // a fresh ready after sent drops guarantees a cs=1 gap between words
            if (!sent && ready) begin
              phase_s = PH_LOAD;
              if (last_s) begin
                state_s      = ST_IDLE;
                idx_s        = 3'd0;
                frame_done_s = (state_r == ST_FRAME);
              end else begin
                idx_s = idx_r + 3'd1;
              end
            end else begin
              phase_s = PH_GAP;
            end
          end
          default: begin
            cs_s    = 1'b1;
            phase_s = PH_LOAD;
          end
        endcase
      end
    endcase
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r      <= ST_INIT;
      phase_r      <= PH_LOAD;
      idx_r        <= 3'd0;
      cs_r         <= 1'b1;
      word_r       <= 16'h0000;
      busy_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      idx_r        <= idx_s;
      cs_r         <= cs_s;
      word_r       <= word_s;
      busy_r       <= (state_s != ST_IDLE);
      frame_done_r <= frame_done_s;
    end
  end

  // request capture: pending flags, overrun, intensity latch and digit snapshot
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tick_q_r    <= 1'b0;
      tick_pend_r <= 1'b0;
      overrun_r   <= 1'b0;
      int_pend_r  <= 1'b0;
      int_val_r   <= 4'h0;
      cfg_val_r   <= 4'h0;
      snap_r      <= 22'h0;
    end else begin
      tick_q_r <= tick;
      if (tick_edge_s) begin
        tick_pend_r <= 1'b1;
      end else if (tick_clr_s) begin
        tick_pend_r <= 1'b0;
      end else begin
        tick_pend_r <= tick_pend_r;
      end
      if (tick_edge_s && tick_pend_r) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
      // a request landing on the CFG entry edge stays pending for another CFG pass
      if (int_req) begin
        int_pend_r <= 1'b1;
        int_val_r  <= int_val;
      end else if (int_clr_s) begin
        int_pend_r <= 1'b0;
        int_val_r  <= int_val_r;
      end else begin
        int_pend_r <= int_pend_r;
        int_val_r  <= int_val_r;
      end
      if (int_clr_s) begin
        cfg_val_r <= int_val_r;
      end else begin
        cfg_val_r <= cfg_val_r;
      end
      if (snap_load_s) begin
        snap_r <= digits;
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  assign cs         = cs_r;
  assign word       = word_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule
